// File: rtl/lockstep_compare_pkg.sv
// Shared types and widths for the lockstep comparator.
package lockstep_compare_pkg;

    localparam int unsigned LANE_W = 4;
    localparam int unsigned CNT_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_CHECK,
        ST_FAIL
    } state_t;

endpackage

// File: rtl/lockstep_delay_line.sv
// Free-running side-A delay line with a fill flag that rises SKEW edges after reset.
module lockstep_delay_line #(
    parameter int unsigned DATA_W = 91,
    parameter int unsigned SKEW   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              filled
);

    localparam logic [2:0] SKEW_L = 3'(SKEW);

    logic [2:0] fill_cnt;

    // Count edges since reset until the pipeline holds SKEW valid stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_cnt <= '0;
        end else if (fill_cnt != SKEW_L) begin
            fill_cnt <= fill_cnt + 3'd1;
        end
    end

    assign filled = (fill_cnt == SKEW_L);

    generate
        if (SKEW == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_pipe
            logic [DATA_W-1:0] stage [SKEW];

            // Shift side-A data one stage per clock; only reset clears it.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int unsigned i = 0; i < SKEW; i++) begin
                        stage[i] <= '0;
                    end
                end else begin
                    stage[0] <= din;
                    for (int unsigned i = 1; i < SKEW; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign dout = stage[SKEW-1];
        end
    endgenerate

endmodule

// File: rtl/lockstep_compare.sv
// Lockstep comparator: delays side A by SKEW, compares all lanes against side B
// on valid cycles, skips WARMUP compares after arming, and latches the first failure.
// Optional capture of the failing lane values: define LOCKSTEP_COMPARE_CAPTURE_EN.
module lockstep_compare
    import lockstep_compare_pkg::*;
#(
    parameter int unsigned WIDTH    = 91,
    parameter int unsigned CHANNELS = 1,
    parameter int unsigned SKEW     = 0,
    parameter int unsigned WARMUP   = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      valid,
    input  logic [CHANNELS*WIDTH-1:0] a_data,
    input  logic [CHANNELS*WIDTH-1:0] b_data,
    output logic                      busy,
    output logic                      mismatch,
    output logic                      fail,
    output logic [LANE_W-1:0]         fail_lane,
    output logic [CNT_W-1:0]          fail_index,
    output logic [CNT_W-1:0]          cmp_count,
    output logic [WIDTH-1:0]          cap_a,
    output logic [WIDTH-1:0]          cap_b
);

    localparam int unsigned DATA_W    = CHANNELS * WIDTH;
    localparam state_t      ARM_STATE = (WARMUP > 0) ? ST_WARMUP : ST_CHECK;
    localparam logic [7:0]  WARM_LAST = (WARMUP > 0) ? 8'(WARMUP - 1) : 8'd0;

    state_t              state;
    logic [7:0]          warm_cnt;
    logic [DATA_W-1:0]   a_dly;
    logic                filled;
    logic [CHANNELS-1:0] lane_diff;
    logic [LANE_W-1:0]   first_lane;
    logic                any_diff;
    logic                compare;
    logic                fail_entry;

    lockstep_delay_line #(
        .DATA_W (DATA_W),
        .SKEW   (SKEW)
    ) u_delay (
        .clk    (clk),
        .rst    (rst),
        .din    (a_data),
        .dout   (a_dly),
        .filled (filled)
    );

    assign busy       = (state == ST_WARMUP) || (state == ST_CHECK);
    assign compare    = valid && filled && busy;
    assign any_diff   = |lane_diff;
    assign fail_entry = compare && any_diff && (state == ST_CHECK) && !start;

    // Per-lane inequality between delayed side A and side B.
    always_comb begin
        lane_diff = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            lane_diff[i] = (a_dly[i*WIDTH +: WIDTH] != b_data[i*WIDTH +: WIDTH]);
        end
    end

    // Lowest-index mismatching lane wins.
    always_comb begin
        logic found;
        found      = 1'b0;
        first_lane = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (lane_diff[i] && !found) begin
                first_lane = LANE_W'(i);
                found      = 1'b1;
            end
        end
    end

    // Arm/warm-up/check/fail sequencing with registered status and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            warm_cnt   <= '0;
            mismatch   <= 1'b0;
            fail       <= 1'b0;
            fail_lane  <= '0;
            fail_index <= '0;
            cmp_count  <= '0;
        end else begin
            mismatch <= 1'b0;
            if (start) begin
                state      <= ARM_STATE;
                warm_cnt   <= '0;
                fail       <= 1'b0;
                fail_lane  <= '0;
                fail_index <= '0;
                cmp_count  <= '0;
            end else begin
                case (state)
                    ST_WARMUP: begin
                        if (compare) begin
                            if (warm_cnt == WARM_LAST) begin
                                state <= ST_CHECK;
                            end
                            warm_cnt <= warm_cnt + 8'd1;
                        end
                    end
                    ST_CHECK: begin
                        if (compare && (cmp_count != '1)) begin
                            cmp_count <= cmp_count + CNT_W'(1);
                        end
                        if (fail_entry) begin
                            state      <= ST_FAIL;
                            mismatch   <= 1'b1;
                            fail       <= 1'b1;
                            fail_lane  <= first_lane;
                            fail_index <= cmp_count;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef LOCKSTEP_COMPARE_CAPTURE_EN
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    assign sel_a = a_dly[int'(first_lane)*WIDTH +: WIDTH];
    assign sel_b = b_data[int'(first_lane)*WIDTH +: WIDTH];

    // Hold the failing lane's values from FAIL entry until re-arm or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_a <= '0;
            cap_b <= '0;
        end else if (start) begin
            cap_a <= '0;
            cap_b <= '0;
        end else if (fail_entry) begin
            cap_a <= sel_a;
            cap_b <= sel_b;
        end
    end
`else
    assign cap_a = '0;
    assign cap_b = '0;
`endif

endmodule

// File: tb/tb_lockstep_compare.sv
// Self-checking bench for lockstep_compare: table vectors, directed corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_lockstep_compare;

    localparam int SK = 2;

`ifdef LOCKSTEP_COMPARE_CAPTURE_EN
    localparam bit CAP_EN = 1'b1;
`else
    localparam bit CAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, valid;
    logic [15:0] a_data, b_data;
    logic        busy, mismatch, fail;
    logic [3:0]  fail_lane;
    logic [31:0] fail_index, cmp_count;
    logic [7:0]  cap_a, cap_b;

    logic        start1, valid1;
    logic [7:0]  a1, b1;
    logic        w_busy, w_mismatch, w_fail;
    logic [3:0]  w_lane;
    logic [31:0] w_index, w_count;
    logic [7:0]  w_capa, w_capb;

    lockstep_compare #(.WIDTH(8), .CHANNELS(2), .SKEW(SK), .WARMUP(0)) dut (
        .clk(clk), .rst(rst), .start(start), .valid(valid),
        .a_data(a_data), .b_data(b_data), .busy(busy), .mismatch(mismatch),
        .fail(fail), .fail_lane(fail_lane), .fail_index(fail_index),
        .cmp_count(cmp_count), .cap_a(cap_a), .cap_b(cap_b)
    );

    lockstep_compare #(.WIDTH(8), .CHANNELS(1), .SKEW(0), .WARMUP(3)) dut_warm (
        .clk(clk), .rst(rst), .start(start1), .valid(valid1),
        .a_data(a1), .b_data(b1), .busy(w_busy), .mismatch(w_mismatch),
        .fail(w_fail), .fail_lane(w_lane), .fail_index(w_index),
        .cmp_count(w_count), .cap_a(w_capa), .cap_b(w_capb)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: armed / failed flags plus a history queue of side-A words.
    bit          m_armed, m_failed;
    logic [31:0] m_cnt, m_idx;
    logic [3:0]  m_lane;
    logic        m_mis;
    logic [7:0]  m_capa, m_capb;
    logic [15:0] a_hist[$];
    int          m_edges;

    task automatic model_reset();
        m_armed = 0; m_failed = 0; m_cnt = 0; m_idx = 0; m_lane = 0;
        m_mis = 0; m_capa = 0; m_capb = 0; m_edges = 0;
        a_hist.delete();
    endtask

    task automatic model_step(input logic st, input logic v, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] ad;
        int bad;
        m_mis = 0;
        if (st) begin
            m_armed = 1; m_failed = 0; m_cnt = 0; m_idx = 0; m_lane = 0;
            m_capa = 0; m_capb = 0;
        end else if (m_armed && v && m_edges >= SK) begin
            ad  = a_hist[a_hist.size() - SK];
            bad = -1;
            for (int l = 0; l < 2; l++)
                if (bad < 0 && ad[8*l +: 8] != b[8*l +: 8]) bad = l;
            if (bad >= 0) begin
                m_idx = m_cnt; m_lane = 4'(bad); m_failed = 1; m_mis = 1; m_armed = 0;
                if (CAP_EN) begin
                    m_capa = ad[8*bad +: 8];
                    m_capb = b[8*bad +: 8];
                end
            end
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end
        a_hist.push_back(a);
        if (a_hist.size() > 8) void'(a_hist.pop_front());
        m_edges++;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".busy"}, 32'(busy), 32'(m_armed));
        chk({tag, ".mismatch"}, 32'(mismatch), 32'(m_mis));
        chk({tag, ".fail"}, 32'(fail), 32'(m_failed));
        chk({tag, ".fail_lane"}, 32'(fail_lane), 32'(m_lane));
        chk({tag, ".fail_index"}, fail_index, m_idx);
        chk({tag, ".cmp_count"}, cmp_count, m_cnt);
        chk({tag, ".cap_a"}, 32'(cap_a), 32'(m_capa));
        chk({tag, ".cap_b"}, 32'(cap_b), 32'(m_capb));
    endtask

    task automatic cycle(input logic st, input logic v, input logic [15:0] a, input logic [15:0] b);
        start = st; valid = v; a_data = a; b_data = b;
        @(posedge clk);
        model_step(st, v, a, b);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1; start = 1'b0; valid = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [15:0] af(input int r);
        return {8'(8'h57 + r), 8'(8'h20 + r)};
    endfunction

    typedef struct {
        logic        st, v;
        logic [15:0] a, b;
        logic        e_busy, e_mis, e_fail;
        logic [3:0]  e_lane;
        logic [31:0] e_idx, e_cnt;
        logic [7:0]  e_capa, e_capb;
    } vec_t;

    vec_t tbl [13];

    task automatic build_table(input bit corrupt);
        for (int r = 0; r < 13; r++) begin
            tbl[r].st = (r == 0);
            tbl[r].v  = (r == 1) || (r >= 3);
            tbl[r].a  = af(r);
            tbl[r].b  = (r >= 2) ? af(r - 2) : 16'hFFFF;
            if (corrupt && r == 6) tbl[r].b[15:8] = 8'h5A;
            tbl[r].e_busy = 1; tbl[r].e_mis = 0; tbl[r].e_fail = 0;
            tbl[r].e_lane = 0; tbl[r].e_idx = 0;
            tbl[r].e_cnt  = (r >= 3) ? 32'(r - 2) : 32'd0;
            tbl[r].e_capa = 0; tbl[r].e_capb = 0;
            if (corrupt && r >= 6) begin
                tbl[r].e_busy = 0; tbl[r].e_mis = (r == 6); tbl[r].e_fail = 1;
                tbl[r].e_lane = 1; tbl[r].e_idx = 3; tbl[r].e_cnt = 4;
                tbl[r].e_capa = CAP_EN ? 8'h5B : 8'h00;
                tbl[r].e_capb = CAP_EN ? 8'h5A : 8'h00;
            end
        end
    endtask

    task automatic run_table(input string tag);
        for (int r = 0; r < 13; r++) begin
            cycle(tbl[r].st, tbl[r].v, tbl[r].a, tbl[r].b);
            chk({tag, ".busy"}, 32'(busy), 32'(tbl[r].e_busy));
            chk({tag, ".mismatch"}, 32'(mismatch), 32'(tbl[r].e_mis));
            chk({tag, ".fail"}, 32'(fail), 32'(tbl[r].e_fail));
            chk({tag, ".fail_lane"}, 32'(fail_lane), 32'(tbl[r].e_lane));
            chk({tag, ".fail_index"}, fail_index, tbl[r].e_idx);
            chk({tag, ".cmp_count"}, cmp_count, tbl[r].e_cnt);
            chk({tag, ".cap_a"}, 32'(cap_a), 32'(tbl[r].e_capa));
            chk({tag, ".cap_b"}, 32'(cap_b), 32'(tbl[r].e_capb));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        rst = 1'b1; start = 0; valid = 0; a_data = 0; b_data = 0;
        start1 = 0; valid1 = 0; a1 = 0; b1 = 0;
        model_reset();

        // Clean skewed stream, then a single-lane corruption on the fourth compare.
        do_reset("reset");
        build_table(1'b0);
        run_table("clean");
        do_reset("reset2");
        build_table(1'b1);
        run_table("lane1_fail");

        // Both lanes corrupt on one compare: lowest lane reported.
        do_reset("reset3");
        cycle(1, 0, af(0), 16'h0);
        for (int r = 1; r <= 6; r++) begin
            cycle(0, r >= 2, af(r), (r == 4) ? (af(r - 2) ^ 16'hFFFF) : af(r - 2));
            check_all("dual");
        end
        chk("dual.fail_lane_const", 32'(fail_lane), 32'd0);
        chk("dual.fail_index_const", fail_index, 32'd2);
        chk("dual.frozen_count", cmp_count, 32'd3);

        // Re-arm from FAIL with a matching stream.
        cycle(1, 1, af(7), af(5));
        check_all("rearm");
        chk("rearm.fail_clear", 32'(fail), 32'd0);
        chk("rearm.count_zero", cmp_count, 32'd0);
        for (int r = 8; r <= 11; r++) begin
            cycle(0, 1, af(r), af(r - 2));
            check_all("rearm_run");
        end
        chk("rearm.count4", cmp_count, 32'd4);

        // Start coincident with a mismatching compare: start wins.
        cycle(1, 1, af(12), af(10) ^ 16'h0100);
        check_all("start_wins");
        chk("start_wins.no_fail", 32'(fail), 32'd0);
        chk("start_wins.no_pulse", 32'(mismatch), 32'd0);
        cycle(0, 1, af(13), af(11));
        chk("start_wins.count1", cmp_count, 32'd1);

        // Reset in the middle of CHECK after five compares.
        do_reset("reset4");
        cycle(1, 0, af(0), 16'h0);
        for (int r = 1; r <= 6; r++) cycle(0, r >= 2, af(r), af(r - 2));
        chk("midrst.count5", cmp_count, 32'd5);
        do_reset("midrst");
        for (int r = 0; r < 2; r++) begin
            cycle(0, 1, af(r), 16'h1234);
            chk("midrst.idle_busy", 32'(busy), 32'd0);
            chk("midrst.no_pulse", 32'(mismatch), 32'd0);
        end
        cycle(1, 0, af(2), 16'h0);
        chk("midrst.rearm_busy", 32'(busy), 32'd1);

        // Warm-up instance: first three compares mismatch and are ignored.
        do_reset("reset5");
        start1 = 1;
        cycle(0, 0, 16'h0, 16'h0);
        start1 = 0;
        chk("warm.busy", 32'(w_busy), 32'd1);
        for (int k = 0; k < 8; k++) begin
            valid1 = 1;
            a1 = 8'($urandom);
            b1 = (k < 3) ? (a1 ^ 8'h01) : a1;
            cycle(0, 0, 16'h0, 16'h0);
            chk("warm.fail", 32'(w_fail), 32'd0);
            chk("warm.mismatch", 32'(w_mismatch), 32'd0);
            if (k == 2) chk("warm.count_after_warmup", w_count, 32'd0);
        end
        valid1 = 0;
        chk("warm.count5", w_count, 32'd5);
        chk("warm.still_busy", 32'(w_busy), 32'd1);

        // Randomized traffic against the reference model.
        do_reset("reset6");
        for (int i = 0; i < 600; i++) begin
            if (i > 0 && $urandom_range(0, 199) == 0) begin
                do_reset("rnd_rst");
            end else begin
                ra = 16'($urandom);
                rb = (a_hist.size() >= SK) ? a_hist[a_hist.size() - SK] : 16'($urandom);
                if ($urandom_range(0, 24) == 0) rb = rb ^ (16'h0001 << $urandom_range(0, 15));
                cycle((i == 0) || ($urandom_range(0, 29) == 0), $urandom_range(0, 9) < 7, ra, rb);
                check_all("rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
